// File: rtl/mdu_iter_pkg.sv
// mdu_pkg: shared encodings for the iterative multiply/divide unit.
// Op codes, FSM state encoding and flag bit positions within {N,Z,C,V}.
package mdu_pkg;

    typedef enum logic [1:0] {
        OP_MUL  = 2'd0,
        OP_MULH = 2'd1,
        OP_DIV  = 2'd2,
        OP_REM  = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_e;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/mdu_iter_if.sv
// mdu_iter_if: request and result handshakes of the multiply/divide unit.
// The unit connects through the slave modport, decode/writeback through master.
interface mdu_iter_if #(
    parameter int WIDTH = 32
);
    logic             start_valid;
    logic             start_ready;
    logic [1:0]       op;
    logic             is_signed;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       dest_in;
    logic             kill;
    logic             busy;
    logic             result_valid;
    logic             result_ready;
    logic [WIDTH-1:0] result;
    logic [3:0]       dest_out;
    logic [3:0]       flags;

    modport slave (
        input  start_valid, op, is_signed, a, b, dest_in, kill, result_ready,
        output start_ready, busy, result_valid, result, dest_out, flags
    );

    modport master (
        output start_valid, op, is_signed, a, b, dest_in, kill, result_ready,
        input  start_ready, busy, result_valid, result, dest_out, flags
    );
endinterface

// File: rtl/mdu_iter_step.sv
// mdu_step: one combinational iteration on the {hi, lo} working pair.
// Multiply mode: conditional add of the multiplicand, then shift right.
// Divide mode (only with MDU_DIV_EN): restoring compare-subtract, shift left.
module mdu_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_hi,
    input  logic [WIDTH-1:0] i_lo,
    input  logic [WIDTH-1:0] i_m,
`ifdef MDU_DIV_EN
    input  logic             i_div,
`endif
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);
    logic [WIDTH:0] w_sum;

    assign w_sum = {1'b0, i_hi} + (i_lo[0] ? {1'b0, i_m} : '0);

`ifdef MDU_DIV_EN
    logic [WIDTH:0]   w_trial;
    logic [WIDTH-1:0] w_diff;
    logic             w_ge;

    // Partial remainder stays below the divisor, so the difference fits WIDTH bits.
    assign w_trial = {i_hi, i_lo[WIDTH-1]};
    assign w_ge    = (w_trial >= {1'b0, i_m});
    assign w_diff  = w_trial[WIDTH-1:0] - i_m;

    // Select shift-add or compare-subtract for this iteration.
    always_comb begin
        o_hi = w_sum[WIDTH:1];
        o_lo = {w_sum[0], i_lo[WIDTH-1:1]};
        if (i_div) begin
            o_hi = w_ge ? w_diff : w_trial[WIDTH-1:0];
            o_lo = {i_lo[WIDTH-2:0], w_ge};
        end
    end
`else
    // Shift-add only: no divider datapath in this build.
    always_comb begin
        o_hi = w_sum[WIDTH:1];
        o_lo = {w_sum[0], i_lo[WIDTH-1:1]};
    end
`endif
endmodule

// File: rtl/mdu_iter.sv
// mdu_iter: iterative multiply/divide unit beside the execute stage.
// Operands are reduced to magnitudes at accept, iterated BITS_PER_CYCLE bits
// per clock, then sign-corrected and flagged in a single FIX cycle.
// Optional feature macro: MDU_DIV_EN (DIV/REM datapath).
module mdu_iter
    import mdu_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic      clk,
    input  logic      rst,
    mdu_iter_if.slave bus
);
    localparam int N  = WIDTH / BITS_PER_CYCLE;
    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] CNT_LOAD = CW'(N - 1);

    state_e           r_state, w_state_next;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_hi, r_lo, r_m;
    op_e              r_op;
    logic             r_signed, r_neg_prod;
    logic [3:0]       r_dest, r_flags;
    logic [WIDTH-1:0] r_result;

    logic             w_accept, w_div_op, w_skip_run, w_sa, w_sb;
    logic [WIDTH-1:0] w_abs_a, w_abs_b;
    logic [2*WIDTH-1:0] w_prod;
    logic             w_mul_c;
    logic [WIDTH-1:0] w_fix_result;
    logic             w_fix_c, w_fix_v;
    logic [3:0]       w_fix_flags;
    logic [WIDTH-1:0] w_hi [BITS_PER_CYCLE+1];
    logic [WIDTH-1:0] w_lo [BITS_PER_CYCLE+1];

    assign w_accept = bus.start_valid && (r_state == S_IDLE) && !bus.kill;
    assign w_div_op = bus.op[1];
    assign w_sa     = bus.is_signed & bus.a[WIDTH-1];
    assign w_sb     = bus.is_signed & bus.b[WIDTH-1];
    assign w_abs_a  = w_sa ? -bus.a : bus.a;
    assign w_abs_b  = w_sb ? -bus.b : bus.b;

`ifdef MDU_DIV_EN
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    logic r_neg_rem, r_dz, r_ovf;
    logic w_dz, w_div_mode;
    assign w_dz       = (bus.b == '0);
    assign w_skip_run = w_div_op && w_dz;
    assign w_div_mode = (r_op == OP_DIV) || (r_op == OP_REM);
`else
    assign w_skip_run = w_div_op;
`endif

    // Iteration chain: BITS_PER_CYCLE steps retired per RUN clock.
    assign w_hi[0] = r_hi;
    assign w_lo[0] = r_lo;
    for (genvar gi = 0; gi < BITS_PER_CYCLE; gi++) begin : g_step
        mdu_step #(.WIDTH(WIDTH)) u_step (
            .i_hi (w_hi[gi]),
            .i_lo (w_lo[gi]),
            .i_m  (r_m),
`ifdef MDU_DIV_EN
            .i_div(w_div_mode),
`endif
            .o_hi (w_hi[gi+1]),
            .o_lo (w_lo[gi+1])
        );
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_state_next;
    end

    // Next-state: kill returns to IDLE from anywhere.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_next = w_skip_run ? S_FIX : S_RUN;
            S_RUN:   if (r_cnt == '0) w_state_next = S_FIX;
            S_FIX:   w_state_next = S_DONE;
            S_DONE:  if (bus.result_ready) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
        if (bus.kill) w_state_next = S_IDLE;
    end

    // Sign-correct the working pair, pick the output, derive {N,Z,C,V}.
    always_comb begin
        w_prod       = r_neg_prod ? -{r_hi, r_lo} : {r_hi, r_lo};
        // C: the full product does not fit in one WIDTH-bit word.
        w_mul_c      = r_signed ? (w_prod[2*WIDTH-1:WIDTH] != {WIDTH{w_prod[WIDTH-1]}})
                                : (w_prod[2*WIDTH-1:WIDTH] != '0);
        w_fix_result = '0;
        w_fix_c      = 1'b0;
        w_fix_v      = 1'b0;
        case (r_op)
            OP_MUL:  begin w_fix_result = w_prod[WIDTH-1:0];       w_fix_c = w_mul_c; end
            OP_MULH: begin w_fix_result = w_prod[2*WIDTH-1:WIDTH]; w_fix_c = w_mul_c; end
            default: begin
`ifdef MDU_DIV_EN
                // Overflow (MIN / -1) already yields MIN and 0 from magnitudes.
                if (r_dz)                 w_fix_result = (r_op == OP_DIV) ? '1 : r_lo;
                else if (r_op == OP_DIV)  w_fix_result = r_neg_prod ? -r_lo : r_lo;
                else                      w_fix_result = r_neg_rem ? -r_hi : r_hi;
                w_fix_v = r_dz | r_ovf;
`else
                w_fix_v = 1'b1;
`endif
            end
        endcase
        w_fix_flags         = '0;
        w_fix_flags[FLAG_N] = w_fix_result[WIDTH-1];
        w_fix_flags[FLAG_Z] = (w_fix_result == '0);
        w_fix_flags[FLAG_C] = w_fix_c;
        w_fix_flags[FLAG_V] = w_fix_v;
    end

    // Datapath: capture at accept, iterate in RUN, latch outputs in FIX.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt      <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_m        <= '0;
            r_op       <= OP_MUL;
            r_signed   <= 1'b0;
            r_neg_prod <= 1'b0;
            r_dest     <= '0;
            r_flags    <= '0;
            r_result   <= '0;
`ifdef MDU_DIV_EN
            r_neg_rem  <= 1'b0;
            r_dz       <= 1'b0;
            r_ovf      <= 1'b0;
`endif
        end else if (w_accept) begin
            r_op       <= op_e'(bus.op);
            r_signed   <= bus.is_signed;
            r_dest     <= bus.dest_in;
            r_neg_prod <= w_sa ^ w_sb;
            r_cnt      <= CNT_LOAD;
            r_hi       <= '0;
            if (w_div_op) begin
                r_lo <= w_abs_a;
                r_m  <= w_abs_b;
            end else begin
                r_lo <= w_abs_b;
                r_m  <= w_abs_a;
            end
`ifdef MDU_DIV_EN
            r_neg_rem <= w_sa;
            r_dz      <= w_div_op && w_dz;
            r_ovf     <= w_div_op && bus.is_signed && (bus.a == MOST_NEG) && (bus.b == '1);
            // Divide by zero skips RUN; keep the raw dividend for the remainder.
            if (w_div_op && w_dz) r_lo <= bus.a;
`endif
        end else if (r_state == S_RUN) begin
            r_hi  <= w_hi[BITS_PER_CYCLE];
            r_lo  <= w_lo[BITS_PER_CYCLE];
            r_cnt <= r_cnt - 1'b1;
        end else if (r_state == S_FIX) begin
            r_result <= w_fix_result;
            r_flags  <= w_fix_flags;
        end
    end

    assign bus.start_ready  = (r_state == S_IDLE) && rst;
    assign bus.busy         = (r_state != S_IDLE);
    assign bus.result_valid = (r_state == S_DONE);
    assign bus.result       = r_result;
    assign bus.dest_out     = r_dest;
    assign bus.flags        = r_flags;
endmodule

// File: tb/tb_mdu_iter.sv
// tb_mdu_iter: vector table, randomized ops against an arithmetic reference
// model, and hand-written sequences for backpressure, kill and mid-op reset.
// Honours MDU_DIV_EN the same way the design does.
module tb_mdu_iter;
    localparam int WIDTH = 32;
    localparam int BPC   = 1;
    localparam int N     = WIDTH / BPC;
    localparam int LAT   = N + 2;
`ifdef MDU_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mdu_iter_if #(.WIDTH(WIDTH)) bus ();
    mdu_iter #(.WIDTH(WIDTH), .BITS_PER_CYCLE(BPC)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        string       name;
        logic [1:0]  op;
        bit          sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [3:0]  fl;
    } vec_t;
    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: plain integer arithmetic on the operand values.
    function automatic void model(input logic [1:0] op, input bit sgn, input logic [31:0] a,
                                  input logic [31:0] b, output logic [31:0] res,
                                  output logic [3:0] fl, output int lat);
        longint      sa, sb, sp;
        logic [63:0] full;
        bit          c, v;
        c = 1'b0; v = 1'b0; lat = LAT; res = '0;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (op < 2'd2) begin
            if (sgn) begin
                sp   = sa * sb;
                full = sp;
                c    = (sp > 64'sd2147483647) || (sp < -64'sd2147483648);
            end else begin
                full = {32'b0, a} * {32'b0, b};
                c    = (full >= 64'h1_0000_0000);
            end
            res = (op == 2'd0) ? full[31:0] : full[63:32];
        end else if (!DIV_EN) begin
            res = '0; v = 1'b1; lat = 2;
        end else if (b == 0) begin
            res = (op == 2'd2) ? 32'hFFFF_FFFF : a; v = 1'b1; lat = 2;
        end else if (sgn) begin
            res = (op == 2'd2) ? 32'(sa / sb) : 32'(sa % sb);
            v   = (sa == -64'sd2147483648) && (sb == -64'sd1);
        end else begin
            res = (op == 2'd2) ? a / b : a % b;
        end
        fl = {res[31], res == 0, c, v};
    endfunction

    // All tasks start and end #1 after a rising edge.
    task automatic issue(input logic [1:0] op, input bit sgn, input logic [31:0] a,
                         input logic [31:0] b, input logic [3:0] dest, output bit ok);
        int w = 0;
        bus.op = op; bus.is_signed = sgn; bus.a = a; bus.b = b; bus.dest_in = dest;
        bus.start_valid = 1'b1;
        while (!bus.start_ready && w < 100) begin @(posedge clk); #1; w++; end
        ok = bus.start_ready;
        @(posedge clk); #1;
        bus.start_valid = 1'b0;
    endtask

    // Latency counts the accept edge as edge 1.
    task automatic wait_valid(output int lat);
        lat = 1;
        while (!bus.result_valid && lat < 200) begin @(posedge clk); #1; lat++; end
    endtask

    task automatic release_result();
        bus.result_ready = 1'b1;
        @(posedge clk); #1;
        bus.result_ready = 1'b0;
    endtask

    task automatic run_vec(input string name, input logic [1:0] op, input bit sgn,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp_res, input logic [3:0] exp_fl, input int exp_lat);
        logic [3:0] dest;
        bit ok;
        int lat;
        dest = 4'($urandom_range(0, 15));
        issue(op, sgn, a, b, dest, ok);
        check({name, "/accept"}, 64'(ok), 64'd1);
        wait_valid(lat);
        check({name, "/latency"}, 64'(lat), 64'(exp_lat));
        check({name, "/result"}, 64'(bus.result), 64'(exp_res));
        check({name, "/flags"}, 64'(bus.flags), 64'(exp_fl));
        check({name, "/dest"}, 64'(bus.dest_out), 64'(dest));
        $display("txn %s op=%0d s=%0d a=%h b=%h -> res=%h flags=%b dest=%h lat=%0d",
                 name, op, sgn, a, b, bus.result, bus.flags, bus.dest_out, lat);
        release_result();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no completion, expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1:0]  op;
        bit          sgn, ok;
        logic [31:0] a, b, res, bp_res;
        logic [3:0]  fl, bp_fl;
        int          lat, seen;

        bus.start_valid = 0; bus.op = 0; bus.is_signed = 0; bus.a = 0; bus.b = 0;
        bus.dest_in = 0; bus.kill = 0; bus.result_ready = 0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst/start_ready", 64'(bus.start_ready), 64'd0);
        check("rst/busy", 64'(bus.busy), 64'd0);
        check("rst/result_valid", 64'(bus.result_valid), 64'd0);
        check("rst/result", 64'(bus.result), 64'd0);
        check("rst/dest_out", 64'(bus.dest_out), 64'd0);
        check("rst/flags", 64'(bus.flags), 64'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst/start_ready_after", 64'(bus.start_ready), 64'd1);

        // Directed vector table
        vecs.push_back('{"mul_u_2p32",  2'd0, 1'b0, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 4'b0110});
        vecs.push_back('{"mulh_s_m3x5", 2'd1, 1'b1, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 4'b1000});
        vecs.push_back('{"mul_s_m3x5",  2'd0, 1'b1, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFF1, 4'b1000});
        vecs.push_back('{"mulh_u_max",  2'd1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 4'b1010});
        vecs.push_back('{"mul_u_3x5",   2'd0, 1'b0, 32'h0000_0003, 32'h0000_0005, 32'h0000_000F, 4'b0000});
        vecs.push_back('{"mul_s_minsq", 2'd0, 1'b1, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 4'b0110});
`ifdef MDU_DIV_EN
        vecs.push_back('{"div_u_100_7", 2'd2, 1'b0, 32'd100,       32'd7,         32'd14,        4'b0000});
        vecs.push_back('{"rem_u_100_7", 2'd3, 1'b0, 32'd100,       32'd7,         32'd2,         4'b0000});
        vecs.push_back('{"div_s_m7_2",  2'd2, 1'b1, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 4'b1000});
        vecs.push_back('{"rem_s_m7_2",  2'd3, 1'b1, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 4'b1000});
        vecs.push_back('{"div_s_7_m2",  2'd2, 1'b1, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 4'b1000});
        vecs.push_back('{"rem_s_7_m2",  2'd3, 1'b1, 32'd7,         32'hFFFF_FFFE, 32'd1,         4'b0000});
        vecs.push_back('{"div_s_ovf",   2'd2, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 4'b1001});
        vecs.push_back('{"rem_s_ovf",   2'd3, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 4'b0101});
        vecs.push_back('{"div_u_by0",   2'd2, 1'b0, 32'd9,         32'd0,         32'hFFFF_FFFF, 4'b1001});
        vecs.push_back('{"rem_u_by0",   2'd3, 1'b0, 32'd9,         32'd0,         32'd9,         4'b0001});
`else
        vecs.push_back('{"div_off",     2'd2, 1'b0, 32'd100,       32'd7,         32'd0,         4'b0101});
        vecs.push_back('{"rem_off",     2'd3, 1'b1, 32'hFFFF_FFF9, 32'd2,         32'd0,         4'b0101});
`endif
        for (int i = 0; i < vecs.size(); i++) begin
            lat = (vecs[i].op[1] && (!DIV_EN || vecs[i].b == 0)) ? 2 : LAT;
            run_vec(vecs[i].name, vecs[i].op, vecs[i].sgn, vecs[i].a, vecs[i].b,
                    vecs[i].res, vecs[i].fl, lat);
        end

        // Randomized ops against the reference model
        for (int i = 0; i < 40; i++) begin
            op  = 2'($urandom_range(0, 3));
            sgn = 1'($urandom_range(0, 1));
            a   = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 7))
                0:       b = 32'd0;
                1:       b = $urandom_range(1, 20);
                2:       b = 32'hFFFF_FFFF;
                default: b = $urandom;
            endcase
            model(op, sgn, a, b, res, fl, lat);
            run_vec("rand", op, sgn, a, b, res, fl, lat);
        end

        // Backpressure: DONE held, outputs stable, new requests ignored
        model(2'd0, 1'b0, 32'h0000_1234, 32'h0000_0010, bp_res, bp_fl, lat);
        issue(2'd0, 1'b0, 32'h0000_1234, 32'h0000_0010, 4'h5, ok);
        check("bp/accept", 64'(ok), 64'd1);
        wait_valid(lat);
        check("bp/latency", 64'(lat), 64'(LAT));
        for (int k = 0; k < 5; k++) begin
            bus.start_valid = 1'b1; bus.a = $urandom; bus.b = $urandom; bus.op = 2'd1;
            @(posedge clk); #1;
            check("bp/result", 64'(bus.result), 64'(bp_res));
            check("bp/flags", 64'(bus.flags), 64'(bp_fl));
            check("bp/start_ready", 64'(bus.start_ready), 64'd0);
            check("bp/result_valid", 64'(bus.result_valid), 64'd1);
        end
        bus.start_valid = 1'b0;
        bus.result_ready = 1'b1;
        @(posedge clk); #1;
        bus.result_ready = 1'b0;
        check("bp/start_ready_after", 64'(bus.start_ready), 64'd1);
        @(posedge clk); #1;
        check("bp/no_stray_accept", 64'(bus.busy), 64'd0);
        $display("txn backpressure res=%h flags=%b", bp_res, bp_fl);

        // Kill 10 cycles into RUN
        issue(2'd0, 1'b0, 32'd123, 32'd456, 4'h3, ok);
        check("kill/accept", 64'(ok), 64'd1);
        repeat (10) @(posedge clk);
        #1;
        bus.kill = 1'b1;
        @(posedge clk); #1;
        bus.kill = 1'b0;
        check("kill/busy", 64'(bus.busy), 64'd0);
        check("kill/start_ready", 64'(bus.start_ready), 64'd1);
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (bus.result_valid) seen++;
        end
        check("kill/valid_cycles", 64'(seen), 64'd0);
        // Kill together with a request in IDLE: not accepted
        bus.start_valid = 1'b1; bus.kill = 1'b1;
        @(posedge clk); #1;
        bus.start_valid = 1'b0; bus.kill = 1'b0;
        check("kill_idle/busy", 64'(bus.busy), 64'd0);
        $display("txn kill done");

        // Reset mid-RUN
        issue(2'd1, 1'b1, 32'hFFFF_FFFD, 32'd5, 4'hA, ok);
        check("midrst/accept", 64'(ok), 64'd1);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("midrst/busy", 64'(bus.busy), 64'd0);
        check("midrst/result_valid", 64'(bus.result_valid), 64'd0);
        check("midrst/result", 64'(bus.result), 64'd0);
        check("midrst/dest_out", 64'(bus.dest_out), 64'd0);
        check("midrst/flags", 64'(bus.flags), 64'd0);
        check("midrst/start_ready", 64'(bus.start_ready), 64'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst/start_ready_after", 64'(bus.start_ready), 64'd1);
        model(2'd1, 1'b1, 32'hFFFF_FFFD, 32'd5, res, fl, lat);
        run_vec("post_rst", 2'd1, 1'b1, 32'hFFFF_FFFD, 32'd5, res, fl, lat);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/mdu_iter.md
# mdu_iter

Parametrised iterative multiply/divide unit for the single-cycle core. It replaces the microcode expansion of multiply and adds high-half multiply, divide and remainder. It sits beside the execute stage. Decode hands it operands plus a destination tag over a valid/ready handshake. It returns a result, tag and NZCV flags over a second valid/ready handshake, and the core stalls fetch while `busy` is high.

## Interface
- Reset is synchronous, active-low (`rst`); single clock `clk`.
- `WIDTH`, 32: operand/result width; even, ≥8.
- `BITS_PER_CYCLE`, 1: bits retired per iteration; must divide `WIDTH` (1, 2, 4).
- `clk`  in  1  core clock.
- `rst`  in  1  synchronous active-low reset.
- `start_valid`  in  1  request present.
- `start_ready`  out  1  unit can accept (IDLE only).
- `op`  in  2  0 MUL (low half), 1 MULH (high half), 2 DIV, 3 REM.
- `is_signed`  in  1  two's-complement operands.
- `a`, `b`  in  WIDTH  operands (dividend/divisor for DIV/REM).
- `dest_in`  in  4  register tag, passed through.
- `kill`  in  1  abandon current operation.
- `busy`  out  1  state ≠ IDLE.
- `result_valid`  out  1  result held.
- `result_ready`  in  1  consumer takes result.
- `result`  out  WIDTH  product half / quotient / remainder.
- `dest_out`  out  4  captured tag.
- `flags`  out  4  {N,Z,C,V}.

## Operation
- States: IDLE, RUN, FIX, DONE.
- IDLE→RUN on `start_valid && start_ready && !kill`. Capture `op`, `is_signed` and `dest_in`. Capture |a| and |b| when signed, and record the result signs.
- RUN: N = WIDTH/BITS_PER_CYCLE iterations.
  - MUL: shift-add into a 2·WIDTH accumulator.
  - DIV/REM: restoring division, quotient and remainder WIDTH each.
  - Counter loads N−1 and decrements; leave RUN when it reaches 0.
- FIX: one cycle. Apply sign correction (quotient sign = sign a ^ sign b, remainder sign = sign a), select the output half, compute flags. →DONE.
- DONE: `result_valid`=1. Outputs are held stable until `result_ready`, then →IDLE.
- Divide by zero: IDLE→FIX directly. Quotient = all ones, remainder = `a`, V=1.
- Signed overflow (DIV of most-negative by −1): quotient = most-negative, remainder = 0, V=1. Runs the full RUN length.
- Flags:
  - N = result[WIDTH−1].
  - Z = (result == 0).
  - C (MUL/MULH) = discarded half not equal to zero-extension (unsigned) or sign-extension (signed) of kept half. C = 0 for DIV/REM.
  - V = 0 except the two cases above.
- `kill` in any state → IDLE next edge and `result_valid` drops. `kill` with `start_valid` in IDLE: request is not accepted.

## Timing
- Reset: state IDLE, counter 0, `result`/`dest_out`/`flags`/`result_valid`/`busy` = 0. `start_ready` = 0 while `rst`=0 and 1 the cycle after release.
- Latency, accept edge to `result_valid` high: N+2 edges (34 at defaults). Divide by zero: 2.
- `start_ready` = (state == IDLE); combinational from state only. No overlap; next accept is earliest the edge after the DONE→IDLE transfer.
- Throughput at defaults: one op per 35 cycles with `result_ready` tied high.
- Reset mid-operation overrides `kill` and handshakes; the unit is in the reset state next edge.

## Configuration
- `MDU_DIV_EN` defined: DIV/REM as above.
- `MDU_DIV_EN` undefined: divider datapath is not compiled. Ops 2/3 go IDLE→FIX, result 0, flags V=1, Z=1, latency 2. MUL/MULH are unchanged.

## Structure
- Package `mdu_pkg`: op encoding constants (MUL, MULH, DIV, REM), state encoding, flag bit indices (N=3, Z=2, C=1, V=0).
- Sub-module `mdu_step`: combinational one-bit step (add-shift or compare-subtract, selected by mode). Instantiated BITS_PER_CYCLE times in a chain inside the RUN datapath.

## Test plan
- MUL unsigned, a=0x0001_0000, b=0x0001_0000 → result 0x0000_0000, flags Z=1 C=1 N=0 V=0, `result_valid` 34 cycles after accept, `dest_out` = `dest_in`.
- MULH signed, a=−3, b=5 → result 0xFFFF_FFFF, N=1 C=0; MUL same operands → 0xFFFF_FFF1.
- DIV unsigned 100/7 → 14; REM → 2. Signed DIV −7/2 → 0xFFFF_FFFD (−3); REM → 0xFFFF_FFFF (−1).
- DIV signed 0x8000_0000 / 0xFFFF_FFFF → 0x8000_0000, V=1. DIV by 0 with a=9 → 0xFFFF_FFFF, V=1, latency 2; REM → 9.
- Backpressure: hold `result_ready`=0 for 5 cycles in DONE → result/flags stable, `start_ready`=0, `start_valid` ignored; raise `result_ready` → `start_ready`=1 next cycle.
- `kill` 10 cycles into RUN → `busy`=0 and `start_ready`=1 next cycle, `result_valid` never asserts. Reset asserted mid-RUN → all outputs 0 the next edge.
